// File: rtl/mult_booth_r8_seq.sv
// mult_booth_r8_seq: sequential radix-8 Booth multiplier for RV32M/RV64M-style MUL, MULH,
// MULHSU and MULHU.
//
// One overlapping 4-bit Booth window of the multiplier is retired per CALC cycle, LSB first.
// The digit value is one of 0, +-M, +-2M, +-3M, +-4M. The hard multiple 3M is captured at
// start, so each cycle needs only one adder. The accumulator is kept as a {hi, lo} pair. The
// digit multiple is added into hi, and the pair is then shifted right arithmetically by 3, so
// digit i lands at weight 8^i. After NDIG steps {hi, lo} holds the exact signed product.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   oper_a       in   multiplicand (rs1), length bits
//   oper_b       in   multiplier (rs2), length bits
//   enable_mult  in   start request, sampled only in IDLE
//   operation    in   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   flush        in   abort the in-flight operation
//   mult_o       out  registered result half (low for MUL, high otherwise)
//   mult_finish  out  one-cycle completion pulse (DONE state)
//   mult_busy    out  high while in CALC
module mult_booth_r8_seq #(
  parameter int unsigned length = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [length-1:0] oper_a,
  input  logic [length-1:0] oper_b,
  input  logic              enable_mult,
  input  logic [1:0]        operation,
  input  logic              flush,
  output logic [length-1:0] mult_o,
  output logic              mult_finish,
  output logic              mult_busy
);

  // Booth digits needed to cover the length+2-bit extended multiplier.
  localparam int unsigned NDIG = (length + 4) / 3;
  // Accumulator high part: extended operand (length+2) plus 3 guard bits. This holds
  // |hi + 4M| < 5 * 2^length without overflow.
  localparam int unsigned HW   = length + 5;
  // Low part collects the 3 bits shifted out per digit.
  localparam int unsigned LW   = 3 * NDIG;
  // Multiplier shift register, including the implicit b[-1] = 0.
  localparam int unsigned BW   = LW + 1;
  // Bits of hi that belong to the 2*length-bit product.
  localparam int unsigned PH   = 2 * length - LW;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_op;
  logic [HW-1:0]     r_m;
  logic [HW-1:0]     r_m3;
  logic [BW-1:0]     r_b;
  logic [HW-1:0]     r_hi;
  logic [LW-1:0]     r_lo;
  logic [length-1:0] r_result;

  logic              w_capture;
  logic              w_step;
  logic              w_last;
  logic              w_a_sx;
  logic              w_b_sx;
  logic [HW-1:0]     w_a_ext;
  logic [LW-1:0]     w_b_ext;
  logic [HW-1:0]     w_a3;
  logic [3:0]        w_win;
  logic [HW-1:0]     w_mag;
  logic              w_neg;
  logic [HW-1:0]     w_sum;
  logic [HW-1:0]     w_hi_next;
  logic [LW-1:0]     w_lo_next;
  logic [2*length-1:0] w_prod;

  // ---------------------------------------------------------------------------------------
  // Capture-time operand extension and hard multiple.
  // MUL uses zero extension; its low half is the same for any extension.
  // ---------------------------------------------------------------------------------------
  assign w_a_sx  = ((operation == OpMulh) || (operation == OpMulhsu)) & oper_a[length-1];
  assign w_b_sx  = (operation == OpMulh) & oper_b[length-1];
  assign w_a_ext = {{(HW - length){w_a_sx}}, oper_a};
  assign w_b_ext = {{(LW - length){w_b_sx}}, oper_b};
  // This adder sits on the capture path only, never in the per-digit loop.
  assign w_a3    = w_a_ext + {w_a_ext[HW-2:0], 1'b0};

  // ---------------------------------------------------------------------------------------
  // Booth digit select. The window is {b[3i+2], b[3i+1], b[3i], b[3i-1]}. Negative digits
  // are applied as an inverted magnitude plus a carry-in of 1. For 4'b1111 this nets to
  // zero (~0 + 1).
  // ---------------------------------------------------------------------------------------
  assign w_win = r_b[3:0];
  assign w_neg = w_win[3];

  always_comb begin
    w_mag = '0;
    unique case (w_win)
      4'b0000, 4'b1111: w_mag = '0;
      4'b0001, 4'b0010,
      4'b1101, 4'b1110: w_mag = r_m;
      4'b0011, 4'b0100,
      4'b1011, 4'b1100: w_mag = {r_m[HW-2:0], 1'b0};
      4'b0101, 4'b0110,
      4'b1001, 4'b1010: w_mag = r_m3;
      4'b0111, 4'b1000: w_mag = {r_m[HW-3:0], 2'b00};
      default:          w_mag = '0;
    endcase
  end

  assign w_sum     = r_hi + (w_mag ^ {HW{w_neg}}) + {{(HW - 1){1'b0}}, w_neg};
  assign w_hi_next = {{3{w_sum[HW-1]}}, w_sum[HW-1:3]};
  assign w_lo_next = {w_sum[2:0], r_lo[LW-1:3]};
  // On the last step the shifted accumulator is the full product.
  assign w_prod    = {w_hi_next[PH-1:0], w_lo_next};

  assign w_last = (r_cnt == CW'(NDIG - 1));

  // ---------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_step       = 1'b0;
    unique case (r_state)
      StIdle: begin
        // flush has priority over a start request.
        if (!flush && enable_mult) begin
          w_state_next = StCalc;
          w_capture    = 1'b1;
        end
      end
      StCalc: begin
        if (flush) begin
          w_state_next = StIdle;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        // A flush here is ignored; the finish pulse is already on the output.
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Datapath. The result register is loaded on the CALC->DONE edge, so mult_o is valid in
  // the finish cycle. It then holds until the next completed operation.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_m      <= '0;
      r_m3     <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (w_capture) begin
      r_cnt <= '0;
      r_op  <= operation;
      r_m   <= w_a_ext;
      r_m3  <= w_a3;
      r_b   <= {w_b_ext, 1'b0};
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (w_step) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      r_b   <= {{3{r_b[BW-1]}}, r_b[BW-1:3]};
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      if (w_last) begin
        r_result <= (r_op == OpMul) ? w_prod[length-1:0] : w_prod[2*length-1:length];
      end
    end
  end

  assign mult_o      = r_result;
  assign mult_finish = (r_state == StDone);
  assign mult_busy   = (r_state == StCalc);

endmodule

// File: tb/tb_mult_booth_r8_seq.sv
// Bench for mult_booth_r8_seq. A 32-bit instance runs the directed cases and a back-to-back
// random run. An 8-bit instance runs a long back-to-back random regression in parallel.
// Expected results are queued at issue time and compared on mult_finish.
module tb_mult_booth_r8_seq;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;
  localparam int N32 = 1000;
  localparam int N8  = 10000;

  logic        clk;
  // 32-bit instance
  logic        rst_n;
  logic [31:0] oper_a, oper_b, mult_o;
  logic        enable_mult, flush, mult_finish, mult_busy;
  logic [1:0]  operation;
  // 8-bit instance
  logic        rst_n8;
  logic [7:0]  oper_a8, oper_b8, mult_o8;
  logic        enable_mult8, flush8, mult_finish8, mult_busy8;
  logic [1:0]  operation8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp8_q[$];
  logic        b2b32 = 1'b0;
  logic        done8 = 1'b0;

  mult_booth_r8_seq #(.length(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .oper_a      (oper_a),
    .oper_b      (oper_b),
    .enable_mult (enable_mult),
    .operation   (operation),
    .flush       (flush),
    .mult_o      (mult_o),
    .mult_finish (mult_finish),
    .mult_busy   (mult_busy)
  );

  mult_booth_r8_seq #(.length(8)) u_dut8 (
    .clk         (clk),
    .rst_n       (rst_n8),
    .oper_a      (oper_a8),
    .oper_b      (oper_b8),
    .enable_mult (enable_mult8),
    .operation   (operation8),
    .flush       (flush8),
    .mult_o      (mult_o8),
    .mult_finish (mult_finish8),
    .mult_busy   (mult_busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RV32M-style reference for width w (w <= 32): full product taken modulo 2^64.
  function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, sa, sb, x, y, p;
    mask = (64'd1 << w) - 64'd1;
    sa = a << (64 - w);
    sa = $signed(sa) >>> (64 - w);
    sb = b << (64 - w);
    sb = $signed(sb) >>> (64 - w);
    x = (op == OP_MULH || op == OP_MULHSU) ? sa : (a & mask);
    y = (op == OP_MULH) ? sb : (b & mask);
    p = x * y;
    return (op == OP_MUL) ? (p & mask) : ((p >> w) & mask);
  endfunction

  function automatic logic [63:0] rnd_val(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = 64'd1 << (w - 1);
      3: v = (64'd1 << (w - 1)) - 64'd1;
      default: ;
    endcase
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  // ---------------------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------------------
  int   cyc32 = 0, last32 = 0;
  logic seen32 = 1'b0, fin_q32 = 1'b0;

  always @(negedge clk) begin
    cyc32   <= cyc32 + 1;
    fin_q32 <= mult_finish;
    if (!b2b32) seen32 <= 1'b0;
    if (rst_n && mult_finish) begin
      if (exp_q.size() == 0) check_eq("unexpected_finish32", 1, 0);
      else check_eq("result32", mult_o, exp_q.pop_front());
      if (fin_q32) check_eq("finish_width32", 1, 0);
      if (b2b32) begin
        if (seen32) check_eq("period32", cyc32 - last32, 14);
        seen32 <= 1'b1;
        last32 <= cyc32;
      end
    end
  end

  int   cyc8 = 0, last8 = 0;
  logic seen8 = 1'b0, fin_q8 = 1'b0;

  always @(negedge clk) begin
    cyc8   <= cyc8 + 1;
    fin_q8 <= mult_finish8;
    if (rst_n8 && mult_finish8) begin
      if (exp8_q.size() == 0) check_eq("unexpected_finish8", 1, 0);
      else check_eq("result8", mult_o8, exp8_q.pop_front());
      if (fin_q8) check_eq("finish_width8", 1, 0);
      if (seen8) check_eq("period8", cyc8 - last8, 6);
      seen8 <= 1'b1;
      last8 <= cyc8;
    end
  end

  // ---------------------------------------------------------------------------------------
  // 32-bit helpers
  // ---------------------------------------------------------------------------------------
  task automatic start_only(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operation   = op;
    oper_a      = a;
    oper_b      = b;
    enable_mult = 1'b1;
    @(posedge clk);
    #1;
    enable_mult = 1'b0;
    // Scramble the inputs; the captured operands must be used.
    oper_a    = ~a;
    oper_b    = ~b;
    operation = ~op;
  endtask

  task automatic wait_fin(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!mult_finish && c < 30);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input string tag);
    int c;
    exp_q.push_back(e);
    start_only(op, a, b);
    wait_fin(c);
    check_eq({tag, "_latency"}, c, 13);
  endtask

  // ---------------------------------------------------------------------------------------
  // 32-bit directed + random
  // ---------------------------------------------------------------------------------------
  initial begin
    int          c, nf, issued, guard;
    logic [31:0] last_exp;
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    rst_n       = 1'b1;
    oper_a      = '0;
    oper_b      = '0;
    operation   = OP_MUL;
    enable_mult = 1'b0;
    flush       = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_mult_o", mult_o, 0);
    check_eq("reset_finish", mult_finish, 0);
    check_eq("reset_busy", mult_busy, 0);
    rst_n = 1'b1;

    run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minxmin");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1xmax");
    run_op(OP_MULHSU, 32'h7FFF_FFFF, 32'h8000_0000, 32'h3FFF_FFFF, "mulhsu_pos");
    run_op(OP_MULH,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, "mulh_minxmax");
    run_op(OP_MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_minxmin");

    // Second start request in CALC cycle 5 must be ignored.
    last_exp = 32'(ref_mul(32, OP_MUL, 64'h1234_5678, 64'h9ABC_DEF0));
    exp_q.push_back(last_exp);
    start_only(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    c = 0;
    repeat (4) begin
      @(negedge clk);
      c++;
      if (c == 1) check_eq("busy_in_calc", mult_busy, 1);
    end
    @(negedge clk);
    c++;
    oper_a      = 32'hFFFF_FFFF;
    oper_b      = 32'h0000_0002;
    operation   = OP_MULHU;
    enable_mult = 1'b1;
    @(posedge clk);
    #1 enable_mult = 1'b0;
    while (!mult_finish && c < 30) begin
      @(negedge clk);
      c++;
    end
    check_eq("ignored_start_latency", c, 13);
    @(negedge clk);
    check_eq("no_queue_busy_a", mult_busy, 0);
    check_eq("no_queue_finish", mult_finish, 0);
    @(negedge clk);
    check_eq("no_queue_busy_b", mult_busy, 0);

    // Flush in DONE: pulse completes, result stays.
    last_exp = 32'(ref_mul(32, OP_MULH, 64'hFFFF_0000, 64'h0003_0000));
    exp_q.push_back(last_exp);
    start_only(OP_MULH, 32'hFFFF_0000, 32'h0003_0000);
    wait_fin(c);
    check_eq("done_flush_latency", c, 13);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("done_flush_hold", mult_o, last_exp);

    // Flush in CALC cycle 4: no finish, IDLE next, mult_o unchanged.
    start_only(OP_MULHU, 32'h1357_9BDF, 32'h2468_ACE0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_idle_busy", mult_busy, 0);
    check_eq("flush_hold_mult_o", mult_o, last_exp);
    nf = 0;
    repeat (16) begin
      @(negedge clk);
      if (mult_finish) nf++;
    end
    check_eq("flush_no_finish", nf, 0);

    // flush beats enable_mult in IDLE.
    @(negedge clk);
    enable_mult = 1'b1;
    flush       = 1'b1;
    @(posedge clk);
    #1;
    enable_mult = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check_eq("flush_prio_busy", mult_busy, 0);

    // Reset for one cycle mid-CALC.
    start_only(OP_MUL, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_mult_o", mult_o, 0);
    check_eq("async_rst_busy", mult_busy, 0);
    check_eq("async_rst_finish", mult_finish, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MULHU, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_0000, "post_rst_mulhu");

    // Back-to-back random run with enable held high.
    b2b32  = 1'b1;
    issued = 0;
    guard  = 0;
    while (issued < N32 && guard < N32 * 20) begin
      @(negedge clk);
      guard++;
      if (!mult_busy && !mult_finish) begin
        ra  = rnd_val(32);
        rb  = rnd_val(32);
        rop = 2'($urandom_range(0, 3));
        oper_a      = ra[31:0];
        oper_b      = rb[31:0];
        operation   = rop;
        enable_mult = 1'b1;
        exp_q.push_back(32'(ref_mul(32, rop, ra, rb)));
        issued++;
      end
    end
    @(posedge clk);
    #1 enable_mult = 1'b0;
    check_eq("issued32", issued, N32);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq("drain32", exp_q.size(), 0);
    b2b32 = 1'b0;

    guard = 0;
    while (!done8 && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("done8_reached", done8, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------------------------------
  // 8-bit back-to-back random regression
  // ---------------------------------------------------------------------------------------
  initial begin
    int          issued, guard;
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    rst_n8       = 1'b1;
    oper_a8      = '0;
    oper_b8      = '0;
    operation8   = OP_MUL;
    enable_mult8 = 1'b0;
    flush8       = 1'b0;
    #2 rst_n8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n8 = 1'b1;
    issued = 0;
    guard  = 0;
    while (issued < N8 && guard < N8 * 8) begin
      @(negedge clk);
      guard++;
      if (!mult_busy8 && !mult_finish8) begin
        ra  = rnd_val(8);
        rb  = rnd_val(8);
        rop = 2'($urandom_range(0, 3));
        oper_a8      = ra[7:0];
        oper_b8      = rb[7:0];
        operation8   = rop;
        enable_mult8 = 1'b1;
        exp8_q.push_back(8'(ref_mul(8, rop, ra, rb)));
        issued++;
      end
    end
    @(posedge clk);
    #1 enable_mult8 = 1'b0;
    check_eq("issued8", issued, N8);
    for (int i = 0; i < 40 && exp8_q.size() != 0; i++) @(negedge clk);
    check_eq("drain8", exp8_q.size(), 0);
    done8 = 1'b1;
  end

endmodule

// File: doc/mult_booth_r8_seq.md
MULT_BOOTH_R8_SEQ -- requirements
Module: mult_booth_r8_seq

Interface
REQ-001 SHALL have parameter `length`, default 32: operand and result width, even, 8..64.
REQ-002 SHALL have derived localparam `NDIG`, equal to ceil((length+2)/3): Booth radix-8 digits per operation; 12 at default.
REQ-003 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port `rst_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port `oper_a`, input, `length` bits: multiplicand (rs1).
REQ-006 SHALL have port `oper_b`, input, `length` bits: multiplier (rs2).
REQ-007 SHALL have port `enable_mult`, input, 1 bit: start request, sampled only in IDLE.
REQ-008 SHALL have port `operation`, input, 2 bits, with encoding 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 SHALL have port `flush`, input, 1 bit: abort the in-flight operation (pipeline kill).
REQ-010 SHALL have port `mult_o`, output, `length` bits: selected result half.
REQ-011 SHALL have port `mult_finish`, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port `mult_busy`, output, 1 bit: high while in CALC.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL transition IDLE->CALC when enable_mult=1 at a clock edge and flush=0 in that cycle.
REQ-015 SHALL, on that edge, capture oper_a, oper_b and operation into registers; later input changes SHALL NOT affect the operation.
REQ-016 SHALL extend captured operands to length+2 bits:
  - oper_a: sign-extended for MULH and MULHSU, zero-extended otherwise.
  - oper_b: sign-extended for MULH only, zero-extended otherwise.
  - MUL uses zero extension (the low half is identical either way).
REQ-017 SHALL precompute the hard multiple 3M into a register at capture time; no combinational 3M adder is allowed in the per-cycle path.
REQ-018 SHALL retire exactly one overlapping 4-bit Booth window per CALC cycle, LSB first, with implicit b[-1]=0.
REQ-019 SHALL select per digit one of 0, ±M, ±2M, ±3M, ±4M and add it to the accumulator at weight 8^i, using a 3-bit arithmetic right shift per cycle.
REQ-020 SHALL size the accumulator so that no overflow occurs for any operand and mode.
REQ-021 SHALL use a digit counter from 0 to NDIG-1 and SHALL transition CALC->DONE after the cycle processing digit NDIG-1 (NDIG CALC cycles).
REQ-022 SHALL set the full 2*length-bit product in DONE.
REQ-023 SHALL drive mult_o with product[length-1:0] for MUL and product[2*length-1:length] otherwise.
REQ-024 SHALL assert mult_finish only in DONE, for exactly one cycle.
REQ-025 SHALL transition DONE->IDLE unconditionally.
REQ-026 SHALL have a latency of NDIG+1 cycles from the start edge to the mult_finish cycle (13 at default).
REQ-027 SHALL give a throughput of one operation per NDIG+2 cycles; enable_mult held high SHALL start a new operation on the first edge in IDLE.
REQ-028 SHALL register mult_o, and SHALL hold it stable from the mult_finish cycle until the next mult_finish.
REQ-029 SHALL ignore enable_mult while in CALC or DONE; no queuing.
REQ-030 SHALL, when flush=1 in CALC, go to IDLE at the next edge with no mult_finish and leave mult_o unchanged.
REQ-031 SHALL, when flush=1 in DONE, still complete the finish pulse.
REQ-032 SHALL let flush take priority over enable_mult in IDLE.
REQ-033 SHALL produce results identical to the RV32M definition for all operand pairs, including the most negative value.

Reset
REQ-034 SHALL, when rst_n=0 (asynchronous, at any time), set state to IDLE, counter to 0, accumulator and operand registers to 0, mult_o=0, mult_finish=0 and mult_busy=0.
REQ-035 SHALL, on reset asserted mid-CALC, abandon the operation with no finish pulse.
REQ-036 SHALL, after rst_n deasserts, accept the first start on the first rising edge at which enable_mult=1.

Verification
REQ-037 SHALL verify MUL: a=0x00000007, b=0xFFFFFFFD -> mult_o=0xFFFFFFEB with mult_finish exactly 13 cycles after the start edge.
REQ-038 SHALL verify the MULH and MULHU extremes:
  - MULH a=b=0x80000000 -> 0x40000000.
  - MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-039 SHALL verify MULHSU: a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
REQ-040 SHALL verify MULHSU: a=0x7FFFFFFF, b=0x80000000 -> 0x3FFFFFFF.
REQ-041 SHALL verify that a second enable_mult pulse with new operands in CALC cycle 5 is ignored and the result matches the first operands.
REQ-042 SHALL verify that flush in CALC cycle 4 gives no mult_finish, IDLE next cycle, and mult_o retaining its previous value.
REQ-043 SHALL verify that rst_n low for one cycle mid-CALC clears all outputs asynchronously, and that a following MULHU 0x0000FFFF*0x00010000 returns 0x00000000.
REQ-044 SHALL verify, in a random regression of at least 10k operations across all four modes with back-to-back starts, that results match a reference model.
